adc_frame_aligner: RTL and testbench

- Parametrised successor to the fixed 4-channel, 14-bit ADC receive path.
- Sits in the system clock domain, after the per-channel clock-crossing FIFOs.
- Buffers each channel in a local FIFO and pops one sample from every channel together, giving aligned frames.
- Optionally averages 2^k frames (decimation), presents the result on a valid/ready output, and reports overflow, activity and frame count.

---
 rtl/adc_frame_pkg.sv | 22 ++
 rtl/adc_ch_fifo.sv | 51 +++++
 rtl/adc_frame_aligner.sv | 109 ++++++++++
 tb/tb_adc_frame_aligner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_pkg.sv
// Shared constants and helpers for the ADC frame aligner and its channel FIFOs.
package adc_frame_pkg;

    localparam int unsigned DEC_W = 3;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Accumulator must hold 2^dec_max full-scale samples without wrapping.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned dec_max);
        return data_w + dec_max;
    endfunction

    function automatic logic [DEC_W-1:0] clamp_k(input logic [DEC_W-1:0] k, input int unsigned kmax);
        if (32'(k) > kmax) begin
            return DEC_W'(kmax);
        end
        return k;
    endfunction

endpackage

// File: rtl/adc_ch_fifo.sv
// Per-channel show-ahead FIFO; the head entry is visible on rdata while not empty.
module adc_ch_fifo
    import adc_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = addr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/adc_frame_aligner.sv
// Aligns per-channel ADC samples into frames, averages 2^k frames and
// presents the result on a valid/ready output with overflow and activity status.
module adc_frame_aligner
    import adc_frame_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_W       = 14,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DEC_MAX_LOG2 = 4
) (
    input  logic                     SysClk,
    input  logic                     Rst_n,
    input  logic                     enable,
    input  logic [DEC_W-1:0]         dec_log2,
    input  logic [NUM_CH-1:0]        in_vld,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        ovf,
    input  logic                     ovf_clr,
    output logic                     activity,
    output logic [31:0]              frame_cnt
);

    localparam int unsigned ACC_W = acc_w(DATA_W, DEC_MAX_LOG2);
    localparam int unsigned CNT_W = (DEC_MAX_LOG2 > 0) ? DEC_MAX_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH-1:0]        wr;
    logic [NUM_CH-1:0]        ovf_ev;
    logic [DATA_W-1:0]        head  [NUM_CH];
    logic [ACC_W-1:0]         acc   [NUM_CH];
    logic [ACC_W-1:0]         sum   [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] frame;
    logic [CNT_W-1:0]         blk_cnt;
    logic [CNT_W-1:0]         blk_mask;
    logic [DEC_W-1:0]         k_lat;
    logic [DEC_W-1:0]         k_eff;
    logic                     pop;
    logic                     dump;

    // A block picks up dec_log2 at its first pop; later pops reuse the latched value.
    assign k_eff    = (blk_cnt == '0) ? clamp_k(dec_log2, DEC_MAX_LOG2) : k_lat;
    assign blk_mask = ~(CNT_ONES << k_eff);
    assign pop      = enable && (empty == '0) && ((blk_cnt != blk_mask) || !out_vld || out_rdy);
    assign dump     = pop && (blk_cnt == blk_mask);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        assign wr[c]     = enable & in_vld[c] & (~full[c] | pop);
        assign ovf_ev[c] = enable & in_vld[c] & full[c] & ~pop;
        assign sum[c]    = acc[c] + ACC_W'(head[c]);
        assign frame[c*DATA_W +: DATA_W] = DATA_W'(sum[c] >> k_eff);

        adc_ch_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (SysClk),
            .rst_n (Rst_n),
            .flush (~enable),
            .wr    (wr[c]),
            .wdata (in_data[c*DATA_W +: DATA_W]),
            .rd    (pop),
            .rdata (head[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            blk_cnt   <= '0;
            k_lat     <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            ovf       <= '0;
            activity  <= 1'b0;
            frame_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
            // Fresh overflow beats a simultaneous clear.
            ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_ev;

            if (blk_cnt == '0) k_lat <= k_eff;

            if (!enable || dump) begin
                blk_cnt <= '0;
                for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
            end else if (pop) begin
                blk_cnt <= blk_cnt + CNT_W'(1);
                for (int c = 0; c < NUM_CH; c++) acc[c] <= sum[c];
            end

            if (dump) begin
                out_vld   <= 1'b1;
                out_data  <= frame;
                activity  <= |frame;
                frame_cnt <= frame_cnt + 32'd1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner with hand-computed expected frames.
module tb_adc_frame_aligner;

    logic        SysClk;
    logic        Rst_n;
    logic        enable;
    logic [2:0]  dec_log2;
    logic [3:0]  in_vld;
    logic [55:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [55:0] out_data;
    logic [3:0]  ovf;
    logic        ovf_clr;
    logic        activity;
    logic [31:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    adc_frame_aligner #(
        .NUM_CH       (4),
        .DATA_W       (14),
        .DEPTH        (8),
        .DEC_MAX_LOG2 (4)
    ) dut (
        .SysClk    (SysClk),
        .Rst_n     (Rst_n),
        .enable    (enable),
        .dec_log2  (dec_log2),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .activity  (activity),
        .frame_cnt (frame_cnt)
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    function automatic logic [55:0] fr(input logic [13:0] a, input logic [13:0] b,
                                       input logic [13:0] c, input logic [13:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [55:0] all4(input logic [13:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [55:0] ovf_frame(input int j);
        return {14'(j * 16 + 3), 14'(j * 16 + 2), 14'(j * 16 + 1), 14'(j * 16)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SysClk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [55:0] d);
        in_vld  = v;
        in_data = d;
        step();
    endtask

    initial begin
        Rst_n    = 1'b0;
        enable   = 1'b0;
        dec_log2 = 3'd0;
        in_vld   = 4'h0;
        in_data  = '0;
        out_rdy  = 1'b0;
        ovf_clr  = 1'b0;
        step();
        step();
        chk("rst_vld",  64'(out_vld),   64'(0));
        chk("rst_data", 64'(out_data),  64'(0));
        chk("rst_ovf",  64'(ovf),       64'(0));
        chk("rst_act",  64'(activity),  64'(0));
        chk("rst_cnt",  64'(frame_cnt), 64'(0));
        Rst_n   = 1'b1;
        enable  = 1'b1;
        out_rdy = 1'b1;
        step();

        // Pass-through, k=0
        drive(4'hF, fr(14'd1, 14'd2, 14'd3, 14'h3FFF));
        in_vld = 4'h0;
        chk("pt_vld_t1", 64'(out_vld), 64'(0));
        step();
        chk("pt_vld_t2", 64'(out_vld),   64'(1));
        chk("pt_data",   64'(out_data),  64'(fr(14'd1, 14'd2, 14'd3, 14'h3FFF)));
        chk("pt_cnt",    64'(frame_cnt), 64'(1));
        chk("pt_act",    64'(activity),  64'(1));
        step();
        chk("pt_accept", 64'(out_vld), 64'(0));

        // Averaging, k=2
        dec_log2 = 3'd2;
        step();
        step();
        drive(4'hF, fr(14'd10, 14'd1, 14'd100, 14'd3));
        drive(4'hF, fr(14'd11, 14'd2, 14'd100, 14'd3));
        drive(4'hF, fr(14'd12, 14'd3, 14'd100, 14'd3));
        drive(4'hF, fr(14'd14, 14'd4, 14'd100, 14'd3));
        in_vld = 4'h0;
        chk("avg2_pending", 64'(out_vld), 64'(0));
        step();
        chk("avg2_vld",  64'(out_vld),   64'(1));
        chk("avg2_data", 64'(out_data),  64'(fr(14'd11, 14'd2, 14'd100, 14'd3)));
        chk("avg2_cnt",  64'(frame_cnt), 64'(2));
        step();

        // Averaging, k=4 at full scale
        dec_log2 = 3'd4;
        step();
        step();
        for (int i = 0; i < 16; i++) drive(4'hF, all4(14'h3FFF));
        in_vld = 4'h0;
        chk("avg4_pending", 64'(out_vld), 64'(0));
        step();
        chk("avg4_vld",  64'(out_vld),   64'(1));
        chk("avg4_data", 64'(out_data),  64'(all4(14'h3FFF)));
        chk("avg4_cnt",  64'(frame_cnt), 64'(3));
        step();

        // Overflow under backpressure
        dec_log2 = 3'd0;
        step();
        step();
        out_rdy = 1'b0;
        for (int j = 1; j <= 10; j++) drive(4'hF, ovf_frame(j));
        in_vld = 4'h0;
        chk("ovf_flags", 64'(ovf), 64'(4'hF));
        out_rdy = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            chk("ovf_drain_vld",  64'(out_vld),  64'(1));
            chk("ovf_drain_data", 64'(out_data), 64'(ovf_frame(j)));
            step();
        end
        chk("ovf_drain_end", 64'(out_vld),   64'(0));
        chk("ovf_cnt",       64'(frame_cnt), 64'(12));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'(0));

        // Channel skew
        drive(4'b0111, fr(14'd5, 14'd6, 14'd7, 14'd0));
        in_vld = 4'h0;
        step();
        chk("skew_wait", 64'(out_vld), 64'(0));
        drive(4'b1000, fr(14'd0, 14'd0, 14'd0, 14'd8));
        in_vld = 4'h0;
        chk("skew_t1", 64'(out_vld), 64'(0));
        step();
        chk("skew_vld",  64'(out_vld),   64'(1));
        chk("skew_data", 64'(out_data),  64'(fr(14'd5, 14'd6, 14'd7, 14'd8)));
        chk("skew_ovf",  64'(ovf),       64'(0));
        chk("skew_cnt",  64'(frame_cnt), 64'(13));

        // All-zero frame clears activity
        drive(4'hF, all4(14'd0));
        in_vld = 4'h0;
        step();
        chk("zero_vld", 64'(out_vld),  64'(1));
        chk("zero_act", 64'(activity), 64'(0));
        step();

        // Mid-block exponent change
        dec_log2 = 3'd2;
        step();
        step();
        drive(4'hF, all4(14'd4));
        drive(4'hF, all4(14'd8));
        dec_log2 = 3'd0;
        drive(4'hF, all4(14'd12));
        drive(4'hF, all4(14'd16));
        in_vld = 4'h0;
        chk("mid_pending", 64'(out_vld), 64'(0));
        step();
        chk("mid_vld",  64'(out_vld),   64'(1));
        chk("mid_data", 64'(out_data),  64'(all4(14'd10)));
        chk("mid_cnt",  64'(frame_cnt), 64'(15));
        drive(4'hF, all4(14'd100));
        in_vld = 4'h0;
        chk("mid_accept", 64'(out_vld), 64'(0));
        step();
        chk("mid_pt_data", 64'(out_data),  64'(all4(14'd100)));
        chk("mid_pt_cnt",  64'(frame_cnt), 64'(16));

        // Disable flushes buffered entries but keeps the pending frame
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) drive(4'hF, all4(14'h55));
        in_vld = 4'h0;
        enable = 1'b0;
        step();
        enable = 1'b1;
        chk("dis_hold_vld",  64'(out_vld),  64'(1));
        chk("dis_hold_data", 64'(out_data), 64'(all4(14'd100)));
        out_rdy = 1'b1;
        step();
        chk("dis_accept", 64'(out_vld), 64'(0));
        step();
        step();
        chk("dis_no_frame", 64'(out_vld),   64'(0));
        chk("dis_cnt",      64'(frame_cnt), 64'(16));

        // Asynchronous reset mid-block with a pending frame
        drive(4'hF, all4(14'd7));
        in_vld  = 4'h0;
        out_rdy = 1'b0;
        step();
        chk("arst_pre_vld", 64'(out_vld), 64'(1));
        dec_log2 = 3'd2;
        step();
        step();
        drive(4'hF, all4(14'd1));
        drive(4'hF, all4(14'd2));
        in_vld = 4'h0;
        step();
        Rst_n = 1'b0;
        #1;
        chk("arst_vld",  64'(out_vld),   64'(0));
        chk("arst_data", 64'(out_data),  64'(0));
        chk("arst_cnt",  64'(frame_cnt), 64'(0));
        chk("arst_act",  64'(activity),  64'(0));
        step();
        Rst_n   = 1'b1;
        out_rdy = 1'b1;
        step();
        step();
        chk("arst_idle", 64'(out_vld), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
